aes_serial_state_mc: RTL and testbench

- Stage directly downstream of the masked byte-serial S-box output stage (2 Boolean shares, first-order).
- Collects the 16 S-box output bytes of a round into a per-share state register, applying ShiftRows on write.
- Then applies MixColumns share-wise, one column per cycle. MixColumns is skipped in the final round.
- Streams the 16 result bytes out serially towards AddRoundKey.
- All operations are linear, so shares are processed independently with no fresh randomness (except the optional feature).

---
 rtl/aes_serial_pkg.sv | 27 ++
 rtl/aes_serial_state_mc_mixcol.sv | 28 ++
 rtl/aes_serial_state_mc.sv | 162 ++++++++++++++++
 tb/tb_aes_serial_state_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_serial_pkg.sv
// Shared types and helpers for the masked serial ShiftRows/MixColumns stage.
package aes_serial_pkg;

    localparam int         NUM_BYTES = 16;
    localparam logic [7:0] POLY      = 8'h1B;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MIX   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    // Byte i = 4c+r lands in column (c-r) mod 4; 2-bit subtraction wraps naturally.
    function automatic logic [3:0] shiftrows_pos(input logic [3:0] idx);
        logic [1:0] c;
        logic [1:0] r;
        c = idx[3:2];
        r = idx[1:0];
        return {2'(c - r), r};
    endfunction

endpackage

// File: rtl/aes_serial_state_mc_mixcol.sv
// One share's MixColumns on a single column; row r sits in bits [8r+7:8r].
module aes_mixcolumn_share
    import aes_serial_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col_i[7:0];
    assign a1 = col_i[15:8];
    assign a2 = col_i[23:16];
    assign a3 = col_i[31:24];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
    assign col_o[7:0]   = x0 ^ x1 ^ a1 ^ a2 ^ a3;
    assign col_o[15:8]  = x1 ^ x2 ^ a2 ^ a3 ^ a0;
    assign col_o[23:16] = x2 ^ x3 ^ a3 ^ a0 ^ a1;
    assign col_o[31:24] = x3 ^ x0 ^ a0 ^ a1 ^ a2;

endmodule

// File: rtl/aes_serial_state_mc.sv
// Masked byte-serial ShiftRows + MixColumns stage (2 Boolean shares).
// Optional AES_SERIAL_OUT_REFRESH_EN adds port r and re-masks each output byte with it.
module aes_serial_state_mc
    import aes_serial_pkg::*;
#(
    parameter int NUM_SHARES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       last_round,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef AES_SERIAL_OUT_REFRESH_EN
    input  logic [7:0] r,
`endif
    output logic       busy,
    output state_e     dbg_state
);

    if (NUM_SHARES != 2) begin : g_bad_shares
        $error("aes_serial_state_mc supports NUM_SHARES == 2 only");
    end

    // Handshakes: a byte moves when valid && ready at a rising clk edge; a presented
    // out byte is held stable until taken, and in_valid outside LOAD is simply ignored.

    state_e                     state_q, state_d;
    logic [3:0]                 byte_cnt_q, byte_cnt_d;
    logic [1:0]                 col_cnt_q, col_cnt_d;
    logic                       last_round_q, last_round_d;
    logic [NUM_BYTES-1:0][7:0]  st0_q, st0_d;
    logic [NUM_BYTES-1:0][7:0]  st1_q, st1_d;
    logic [7:0]                 out0_q, out0_d;
    logic [7:0]                 out1_q, out1_d;

    logic [7:0]  mask;
    logic [3:0]  wr_pos;
    logic [3:0]  cnt_inc;
    logic [31:0] mc_in0, mc_in1, mc_out0, mc_out1;

`ifdef AES_SERIAL_OUT_REFRESH_EN
    assign mask = r;
`else
    assign mask = 8'h00;
`endif

    assign wr_pos  = shiftrows_pos(byte_cnt_q);
    assign cnt_inc = byte_cnt_q + 4'd1;

    assign mc_in0 = {st0_q[{col_cnt_q, 2'd3}], st0_q[{col_cnt_q, 2'd2}],
                     st0_q[{col_cnt_q, 2'd1}], st0_q[{col_cnt_q, 2'd0}]};
    assign mc_in1 = {st1_q[{col_cnt_q, 2'd3}], st1_q[{col_cnt_q, 2'd2}],
                     st1_q[{col_cnt_q, 2'd1}], st1_q[{col_cnt_q, 2'd0}]};

    aes_mixcolumn_share u_mc_share0 (.col_i(mc_in0), .col_o(mc_out0));
    aes_mixcolumn_share u_mc_share1 (.col_i(mc_in1), .col_o(mc_out1));

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        col_cnt_d    = col_cnt_q;
        last_round_d = last_round_q;
        st0_d        = st0_q;
        st1_d        = st1_q;
        out0_d       = out0_q;
        out1_d       = out1_q;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    st0_d[wr_pos] = in0;
                    st1_d[wr_pos] = in1;
                    byte_cnt_d    = cnt_inc;
                    if (byte_cnt_q == 4'd0) begin
                        last_round_d = last_round;
                    end
                    if (byte_cnt_q == 4'd15) begin
                        col_cnt_d = 2'd0;
                        if (last_round_q) begin
                            state_d = DRAIN;
                            out0_d  = st0_d[0] ^ mask;
                            out1_d  = st1_d[0] ^ mask;
                        end else begin
                            state_d = MIX;
                        end
                    end
                end
            end
            MIX: begin
                st0_d[{col_cnt_q, 2'd0}] = mc_out0[7:0];
                st0_d[{col_cnt_q, 2'd1}] = mc_out0[15:8];
                st0_d[{col_cnt_q, 2'd2}] = mc_out0[23:16];
                st0_d[{col_cnt_q, 2'd3}] = mc_out0[31:24];
                st1_d[{col_cnt_q, 2'd0}] = mc_out1[7:0];
                st1_d[{col_cnt_q, 2'd1}] = mc_out1[15:8];
                st1_d[{col_cnt_q, 2'd2}] = mc_out1[23:16];
                st1_d[{col_cnt_q, 2'd3}] = mc_out1[31:24];
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = DRAIN;
                    out0_d  = st0_d[0] ^ mask;
                    out1_d  = st1_d[0] ^ mask;
                end
            end
            DRAIN: begin
                // byte_cnt_q doubles as the drain index; it is 0 on entry from either path.
                if (out_ready) begin
                    byte_cnt_d = cnt_inc;
                    if (byte_cnt_q == 4'd15) begin
                        state_d = LOAD;
                        out0_d  = 8'h00;
                        out1_d  = 8'h00;
                    end else begin
                        out0_d = st0_q[cnt_inc] ^ mask;
                        out1_d = st1_q[cnt_inc] ^ mask;
                    end
                end
            end
            default: begin
                state_d    = LOAD;
                byte_cnt_d = 4'd0;
                col_cnt_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            byte_cnt_q   <= 4'd0;
            col_cnt_q    <= 2'd0;
            last_round_q <= 1'b0;
            st0_q        <= '0;
            st1_q        <= '0;
            out0_q       <= 8'h00;
            out1_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            col_cnt_q    <= col_cnt_d;
            last_round_q <= last_round_d;
            st0_q        <= st0_d;
            st1_q        <= st1_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign busy      = !((state_q == LOAD) && (byte_cnt_q == 4'd0));
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_serial_state_mc.sv
// Scoreboard bench for aes_serial_state_mc: directed FIPS-197 vectors plus randomized rounds.
module tb_aes_serial_state_mc;
    import aes_serial_pkg::*;

    typedef logic [15:0][7:0] blk_t;

`ifdef AES_SERIAL_OUT_REFRESH_EN
    localparam logic [7:0] RMASK = 8'ha5;
`else
    localparam logic [7:0] RMASK = 8'h00;
`endif
    localparam int WAIT_BUDGET = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in0, in1;
    logic       in_valid, in_ready, last_round;
    logic [7:0] out0, out1;
    logic       out_valid, out_ready;
    logic       busy;
    state_e     dbg_state;
`ifdef AES_SERIAL_OUT_REFRESH_EN
    logic [7:0] r = RMASK;
`endif

    aes_serial_state_mc #(.NUM_SHARES(2)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in_valid(in_valid), .in_ready(in_ready),
        .last_round(last_round),
        .out0(out0), .out1(out1), .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_SERIAL_OUT_REFRESH_EN
        .r(r),
`endif
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          acc_q[$];
    int          elat_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rounds = 0;
    int          popped = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic       hi;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa ^= 8'h1b;
        end
        return p;
    endfunction

    function automatic blk_t ref_round(input blk_t x, input bit lr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        blk_t y;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                s[rr][c] = x[4*c + rr];
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                t[rr][c] = s[rr][(c + rr) % 4];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                y[4*c + rr] = lr ? t[rr][c]
                                 : gmul(8'h02, t[rr][c]) ^ gmul(8'h03, t[(rr+1)%4][c])
                                   ^ t[(rr+2)%4][c] ^ t[(rr+3)%4][c];
        return y;
    endfunction

    // Hex literal written in stream order: first byte is index 0.
    function automatic blk_t from_hex(input logic [127:0] h);
        blk_t y;
        for (int i = 0; i < 16; i++) y[i] = h[127 - 8*i -: 8];
        return y;
    endfunction

    function automatic blk_t rand_blk();
        blk_t y;
        for (int i = 0; i < 16; i++) y[i] = 8'($urandom_range(0, 255));
        return y;
    endfunction

    // ---------------- driver ----------------
    // Sends bytes 0..stop_after-1; a full round (stop_after = 16) queues its expectations.
    task automatic send_round(input blk_t s0, input blk_t s1, input bit lr,
                              input blk_t e0, input blk_t e1, input int stop_after);
        int k;
        for (int i = 0; i < stop_after; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in0        = s0[i];
            in1        = s1[i];
            last_round = (i == 0) ? lr : 1'($urandom_range(0, 1));
            in_valid   = 1'b1;
            k = 0;
            @(negedge clk);
            while (!in_ready && k < WAIT_BUDGET) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == 15) begin
                acc_q.push_back(cyc);
                elat_q.push_back(lr ? 1 : 5);
                for (int b = 0; b < 16; b++)
                    exp_q.push_back({e1[b] ^ RMASK, e0[b] ^ RMASK});
                n_rounds++;
            end
        end
        in_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        logic [15:0] e;
        int a;
        int l;
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({out1, out0}), 32'(prev_data));
            end
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_round", 32'(out_valid), 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    l = elat_q.pop_front();
                    check("latency", 32'(cyc - a + 1), 32'(l));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check("out_byte", 32'({out1, out0}), 32'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = {out1, out0};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        blk_t x, mc, lrv, sh, ref1, col_in, col_out, zero, s0, s1;
        int k;
        x       = from_hex(128'hd42711aee0bf98f1b8b45de51e415230);
        mc      = from_hex(128'h046681e5e0cb199a48f8d37a2806264c);
        lrv     = from_hex(128'hd4bf5d30e0b452aeb84111f11e2798e5);
        col_in  = from_hex(128'hdb000000_00130000_00005300_00000045);
        col_out = from_hex(128'h8e4da1bc_00000000_00000000_00000000);
        zero    = '0;

        rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; last_round = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out", 32'({out1, out0}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 round 1 with a zero second share
        send_round(x, zero, 1'b0, mc, zero, 16);

        // Random share split: share 1 follows its own linear image
        sh   = rand_blk();
        ref1 = ref_round(sh, 1'b0);
        send_round(x ^ sh, sh, 1'b0, mc ^ ref1, ref1, 16);

        // Final round skips MixColumns
        send_round(x, zero, 1'b1, lrv, zero, 16);

        // Single diagonal that ShiftRows gathers into column 0
        send_round(col_in, zero, 1'b0, col_out, zero, 16);

        // Mid-round reset after 7 bytes discards the partial round
        k = 0;
        while ((in_ready !== 1'b1 || busy !== 1'b0) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        send_round(rand_blk(), rand_blk(), 1'b0, zero, zero, 7);
        @(negedge clk);
        check("busy_mid_round", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        s0 = rand_blk();
        s1 = rand_blk();
        send_round(s0, s1, 1'b0, ref_round(s0, 1'b0), ref_round(s1, 1'b0), 16);

        // Random rounds with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            bit lr;
            lr = 1'($urandom_range(0, 1));
            s0 = rand_blk();
            s1 = rand_blk();
            send_round(s0, s1, lr, ref_round(s0, lr), ref_round(s1, lr), 16);
        end

        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        rand_ready = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("byte_count", 32'(popped), 32'(16 * n_rounds));
        repeat (2) @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
